// File: rtl/lsu_bus_master.sv
// Load/store unit Wishbone pipelined bus master: one request in, one bus transfer, one response out.
// Optional build macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus cycle.
module lsu_bus_master #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TIMEOUT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [4:0]  req_rd_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i
);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_ACK, RESPOND} state_t;

  localparam int unsigned TMO_LAST = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

  state_t               state, state_nxt;
  logic [TIMEOUT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic                 lat_we, lat_unsigned;
  logic [1:0]           lat_size, lat_off;
  logic [4:0]           lat_rd;
  logic                 accept, timeout;
  logic [3:0]           sel_c;
  logic [31:0]          wdat_c, load_c, shift_b, shift_h;

  logic        ready_d, rsp_valid_d, rsp_err_d, cyc_d, stb_d, we_d;
  logic [31:0] rsp_data_d, adr_d, dat_d;
  logic [4:0]  rsp_rd_d;
  logic [3:0]  sel_d;

  assign accept  = req_valid_i & req_ready_o;
  assign timeout = (ACK_TIMEOUT != 0) && (tmo_cnt == TIMEOUT_W'(TMO_LAST));

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((req_size_i == 2'd1) && req_addr_i[0]) ||
                    (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`endif

  // Byte-lane select and store data replication from the incoming request
  always_comb begin
    sel_c  = 4'b1111;
    wdat_c = req_wdata_i;
    case (req_size_i)
      2'd0: begin
        sel_c  = 4'b0001 << req_addr_i[1:0];
        wdat_c = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        sel_c  = 4'b0011 << {req_addr_i[1], 1'b0};
        wdat_c = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Read data extraction and sign/zero extension for the latched request
  always_comb begin
    shift_b = wb_dat_i >> {lat_off, 3'b000};
    shift_h = wb_dat_i >> {lat_off[1], 4'b0000};
    load_c  = wb_dat_i;
    case (lat_size)
      2'd0: load_c = lat_unsigned ? {24'h0, shift_b[7:0]} : {{24{shift_b[7]}}, shift_b[7:0]};
      2'd1: load_c = lat_unsigned ? {16'h0, shift_h[15:0]} : {{16{shift_h[15]}}, shift_h[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_CHECK_EN
          state_nxt = misalign ? RESPOND : REQUEST;
`else
          state_nxt = REQUEST;
`endif
        end
      end
      REQUEST:  if (!wb_stall_i) state_nxt = WAIT_ACK;
      WAIT_ACK: if (wb_ack_i || timeout) state_nxt = RESPOND;
      RESPOND:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the ack timeout counter
  always_comb begin
    ready_d     = (state_nxt == IDLE);
    cyc_d       = (state_nxt == REQUEST) || (state_nxt == WAIT_ACK);
    stb_d       = (state_nxt == REQUEST);
    rsp_valid_d = (state_nxt == RESPOND);
    rsp_data_d  = 32'h0;
    rsp_err_d   = 1'b0;
    rsp_rd_d    = 5'h0;
    adr_d       = wb_adr_o;
    dat_d       = wb_dat_o;
    we_d        = wb_we_o;
    sel_d       = wb_sel_o;
    tmo_cnt_nxt = tmo_cnt;
    if (state == IDLE && accept) begin
      adr_d = {req_addr_i[31:2], 2'b00};
      dat_d = wdat_c;
      we_d  = req_we_i;
      sel_d = sel_c;
    end
    if (state == REQUEST && !wb_stall_i) tmo_cnt_nxt = '0;
    if (state == WAIT_ACK) begin
      tmo_cnt_nxt = tmo_cnt + TIMEOUT_W'(1);
      if (wb_ack_i)     rsp_data_d = lat_we ? 32'h0 : load_c;
      else if (timeout) rsp_err_d  = 1'b1;
    end
    if (state_nxt == RESPOND) begin
      rsp_rd_d = (state == IDLE) ? req_rd_i : lat_rd;
      if (state == IDLE) rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 32'h0;
      rsp_rd_o    <= 5'h0;
      rsp_err_o   <= 1'b0;
      wb_adr_o    <= 32'h0;
      wb_dat_o    <= 32'h0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= 4'h0;
      wb_stb_o    <= 1'b0;
      wb_cyc_o    <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      req_ready_o <= ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o  <= rsp_data_d;
      rsp_rd_o    <= rsp_rd_d;
      rsp_err_o   <= rsp_err_d;
      wb_adr_o    <= adr_d;
      wb_dat_o    <= dat_d;
      wb_we_o     <= we_d;
      wb_sel_o    <= sel_d;
      wb_stb_o    <= stb_d;
      wb_cyc_o    <= cyc_d;
      tmo_cnt     <= tmo_cnt_nxt;
    end
  end

  // Request attributes needed after the bus phase
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'd0;
      lat_off      <= 2'd0;
      lat_rd       <= 5'h0;
    end else if (accept) begin
      lat_we       <= req_we_i;
      lat_unsigned <= req_unsigned_i;
      lat_size     <= req_size_i;
      lat_off      <= req_addr_i[1:0];
      lat_rd       <= req_rd_i;
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed cases plus randomized accesses against a reference model.
module tb_lsu_bus_master;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic [4:0]  req_rd_i, rsp_rd_o;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_data_o, wb_adr_o, wb_dat_i, wb_dat_o;
  logic        wb_we_o, wb_stb_o, wb_ack_i, wb_cyc_o, wb_stall_i;
  logic [3:0]  wb_sel_o;

  int total = 0;
  int bad   = 0;

  lsu_bus_master #(.ACK_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_rd_i(req_rd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
    .wb_stall_i(wb_stall_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: lane arithmetic straight from the byte/half/word rules
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns, input logic [31:0] d);
    int unsigned lane, v;
    if (size == 2'd0) begin
      lane = addr % 32'd4;
      v = (d >> (8 * lane)) % 32'd256;
      if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      lane = ((addr % 32'd4) / 32'd2) * 32'd2;
      v = (d >> (8 * lane)) % 32'd65536;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_sel(input logic [31:0] addr, input logic [1:0] size);
    int unsigned s;
    if (size == 2'd0)      s = 32'd1 << (addr % 32'd4);
    else if (size == 2'd1) s = 32'd3 << (((addr % 32'd4) / 32'd2) * 32'd2);
    else                   s = 32'd15;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdat(input logic [31:0] w, input logic [1:0] size);
    if (size == 2'd0) return (w % 32'd256) * 32'h01010101;
    if (size == 2'd1) return (w % 32'd65536) * 32'h00010001;
    return w;
  endfunction

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns, input logic [4:0] rd);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_size_i = size; req_unsigned_i = uns; req_rd_i = rd;
  endtask

  task automatic xfer(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [1:0] size, input logic uns, input logic [4:0] rd,
                      input int stall, input int dly, input logic [31:0] rdat);
    logic [31:0] exp_rsp;
    exp_rsp = we ? 32'h0 : ref_load(addr, size, uns, rdat);
    check({tag, ".ready_idle"}, 32'(req_ready_o), 32'd1);
    drive_req(we, addr, wdata, size, uns, rd);
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i <= stall; i++) begin
      wb_stall_i = (i < stall);
      wb_ack_i = (i == stall) ? 1'($urandom_range(0, 1)) : 1'b0;
      check({tag, ".cyc_req"}, 32'(wb_cyc_o), 32'd1);
      check({tag, ".stb_req"}, 32'(wb_stb_o), 32'd1);
      check({tag, ".adr"}, wb_adr_o, addr & 32'hFFFFFFFC);
      check({tag, ".sel"}, 32'(wb_sel_o), ref_sel(addr, size));
      check({tag, ".we"}, 32'(wb_we_o), 32'(we));
      if (we) check({tag, ".dat_o"}, wb_dat_o, ref_wdat(wdata, size));
      check({tag, ".ready_busy"}, 32'(req_ready_o), 32'd0);
      step();
    end
    wb_stall_i = 1'b0;
    for (int j = 0; j <= dly; j++) begin
      check({tag, ".cyc_wait"}, 32'(wb_cyc_o), 32'd1);
      check({tag, ".stb_wait"}, 32'(wb_stb_o), 32'd0);
      check({tag, ".no_rsp"}, 32'(rsp_valid_o), 32'd0);
      wb_ack_i = (j == dly);
      wb_dat_i = (j == dly) ? rdat : $urandom;
      step();
    end
    wb_ack_i = 1'b0;
    check({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    check({tag, ".rsp_data"}, rsp_data_o, exp_rsp);
    check({tag, ".rsp_rd"}, 32'(rsp_rd_o), 32'(rd));
    check({tag, ".rsp_err"}, 32'(rsp_err_o), 32'd0);
    check({tag, ".cyc_rsp"}, 32'(wb_cyc_o), 32'd0);
    step();
    check({tag, ".rsp_pulse"}, 32'(rsp_valid_o), 32'd0);
    check({tag, ".ready_back"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    logic        r_we, r_uns;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    rst_i = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
    req_size_i = 2'd0; req_unsigned_i = 1'b0; req_rd_i = 5'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    step();
    step();
    check("rst.ready", 32'(req_ready_o), 32'd1);
    check("rst.cyc", 32'(wb_cyc_o), 32'd0);
    check("rst.stb", 32'(wb_stb_o), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst.sel", 32'(wb_sel_o), 32'd0);
    check("rst.adr", wb_adr_o, 32'd0);
    rst_i = 1'b1;
    step();

    xfer("lw100", 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 5'd7, 0, 0, 32'hDEADBEEF);
    xfer("lb203s", 1'b0, 32'h203, 32'h0, 2'd0, 1'b0, 5'd3, 0, 0, 32'h80FFFFFF);
    xfer("lb203u", 1'b0, 32'h203, 32'h0, 2'd0, 1'b1, 5'd4, 0, 1, 32'h80FFFFFF);
    xfer("sh302", 1'b1, 32'h302, 32'h1234, 2'd1, 1'b0, 5'd9, 3, 0, 32'hFFFFFFFF);
    xfer("lh_hi", 1'b0, 32'h402, 32'h0, 2'd1, 1'b0, 5'd12, 1, 2, 32'h9ABC5678);

    // Ack never arrives: four wait cycles then an error response
    drive_req(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, 5'd21);
    step();
    req_valid_i = 1'b0;
    check("tmo.stb", 32'(wb_stb_o), 32'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      check("tmo.cyc_wait", 32'(wb_cyc_o), 32'd1);
      check("tmo.no_rsp", 32'(rsp_valid_o), 32'd0);
      step();
    end
    check("tmo.cyc_drop", 32'(wb_cyc_o), 32'd0);
    check("tmo.rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("tmo.rsp_err", 32'(rsp_err_o), 32'd1);
    check("tmo.rsp_data", rsp_data_o, 32'd0);
    check("tmo.rsp_rd", 32'(rsp_rd_o), 32'd21);
    wb_ack_i = 1'b1;
    wb_dat_i = 32'h11111111;
    step();
    wb_ack_i = 1'b0;
    check("tmo.ready_back", 32'(req_ready_o), 32'd1);
    check("tmo.late_ack", 32'(rsp_valid_o), 32'd0);

    // Reset while waiting for ack
    drive_req(1'b1, 32'h600, 32'hCAFEF00D, 2'd2, 1'b0, 5'd5);
    step();
    req_valid_i = 1'b0;
    step();
    check("rstw.cyc_wait", 32'(wb_cyc_o), 32'd1);
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    check("rstw.cyc", 32'(wb_cyc_o), 32'd0);
    check("rstw.stb", 32'(wb_stb_o), 32'd0);
    check("rstw.rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rstw.ready", 32'(req_ready_o), 32'd1);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    check("rstw.no_rsp", 32'(rsp_valid_o), 32'd0);
    check("rstw.idle_cyc", 32'(wb_cyc_o), 32'd0);

`ifdef LSU_MISALIGN_CHECK_EN
    drive_req(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 5'd17);
    step();
    req_valid_i = 1'b0;
    check("mis.cyc", 32'(wb_cyc_o), 32'd0);
    check("mis.rsp_valid", 32'(rsp_valid_o), 32'd1);
    check("mis.rsp_err", 32'(rsp_err_o), 32'd1);
    check("mis.rsp_data", rsp_data_o, 32'd0);
    check("mis.rsp_rd", 32'(rsp_rd_o), 32'd17);
    step();
    check("mis.ready", 32'(req_ready_o), 32'd1);
    check("mis.cyc_after", 32'(wb_cyc_o), 32'd0);
`else
    xfer("lw101", 1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 5'd17, 0, 0, 32'h01234567);
`endif

    for (int n = 0; n < 40; n++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = 2'($urandom_range(0, 3));
      r_addr = $urandom;
`ifdef LSU_MISALIGN_CHECK_EN
      if (r_size == 2'd1) r_addr[0] = 1'b0;
      if (r_size[1]) r_addr[1:0] = 2'b00;
`endif
      xfer("rnd", r_we, r_addr, $urandom, r_size, r_uns, 5'($urandom_range(0, 31)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store bus master that turns one memory request from the execute stage into a single Wishbone pipelined transfer.
- Handles byte-lane steering, write-data replication, read-data extraction and sign extension.
- Returns a one-cycle response to writeback.
- Its master port drives the data-side slave port of the core's two-port Wishbone arbiter.

Parameters:
- ACK_TIMEOUT, 255, max cycles waiting for ack after strobe accepted; 0 disables timeout.
- TIMEOUT_W, 8, width of timeout counter; ACK_TIMEOUT must fit in TIMEOUT_W bits.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when valid&&ready
- req_we_i  in  1  1=store, 0=load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- req_size_i  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_unsigned_i  in  1  load zero-extends when 1
- req_rd_i  in  5  destination register tag, echoed back
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_data_o  out  32  load result, 0 for stores
- rsp_rd_o  out  5  echoed tag
- rsp_err_o  out  1  access error
- wb_adr_o  out  32  word address {addr[31:2],2'b00}
- wb_dat_i  in  32  read data
- wb_dat_o  out  32  write data
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte lanes
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  ack
- wb_cyc_o  out  1  cycle
- wb_stall_i  in  1  stall

Behaviour:
- Reset (rst_i=0 at edge): state IDLE, req_ready_o=1, all other outputs 0, timeout counter 0.
- Reset mid-transfer drops cyc/stb on the next edge and produces no response.
- FSM: IDLE, REQUEST, WAIT_ACK, RESPOND.
- IDLE:
  - req_ready_o=1.
  - On accept, latch we/addr/wdata/size/unsigned/rd, then go to REQUEST.
  - req_ready_o=0 in all other states; one outstanding transfer max.
- REQUEST:
  - cyc=1, stb=1, adr/dat/we/sel driven from the latched request.
  - wb_stall_i=1: hold all outputs unchanged.
  - wb_stall_i=0: strobe accepted; go to WAIT_ACK, clear counter.
  - Ack in the same cycle as acceptance is not legal and is ignored.
- WAIT_ACK:
  - cyc=1, stb=0.
  - On wb_ack_i: capture wb_dat_i, go to RESPOND.
  - Otherwise increment counter. If ACK_TIMEOUT!=0 and counter reaches ACK_TIMEOUT-1 without ack: go to RESPOND with err=1, data 0.
  - A late ack after timeout is ignored because cyc has already dropped.
- RESPOND:
  - cyc=0, rsp_valid_o=1 for exactly one cycle, then IDLE.
  - Best case latency: accept N, stb N+1, ack N+2, rsp_valid_o N+3.
- Byte lanes (o = addr[1:0]):
  - byte: sel=4'b0001<<o; wdata replicated {4{b}}.
  - half: sel=4'b0011<<{o[1],1'b0}; wdata {2{h}}.
  - word: sel=4'b1111.
- Load extraction:
  - Shift wb_dat_i right by 8*o (half uses o[1] only).
  - Take low 8 or 16 bits; sign-extend unless req_unsigned_i=1. Word is passed unchanged.
- Store responses: rsp_data_o=0, rsp_err_o=0 unless timeout.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, raises no bus cycle.
  - IDLE goes directly to RESPOND; rsp_err_o=1, rsp_data_o=0, rsp_valid_o one cycle after accept.
- Undefined:
  - Low address bits below access size are ignored: half uses addr[1], word uses none.
  - rsp_err_o is set only by timeout.

Test Plan:
- Load word addr 0x100, stall 0, ack next cycle with 0xDEADBEEF -> adr 0x100, sel 1111, we 0, rsp_data 0xDEADBEEF at accept+3, rsp_rd echoed.
- Load byte signed addr 0x203, dat_i 0x80FFFFFF -> sel 1000, rsp_data 0xFFFFFF80; same access unsigned -> 0x00000080.
- Store half 0x1234 to addr 0x302 with wb_stall_i high 3 cycles -> stb/adr/sel 1100/dat 0x12341234 held stable 4 cycles, one ack, rsp_valid pulse with data 0.
- ACK_TIMEOUT=4, never ack -> cyc drops after 4 WAIT_ACK cycles, rsp_err 1, rsp_data 0, req_ready back to 1 the next cycle.
- rst_i low during WAIT_ACK -> cyc/stb 0 next edge, no rsp_valid, req_ready 1.
- With LSU_MISALIGN_CHECK_EN, load word addr 0x101 -> cyc never asserted, rsp_err 1 one cycle after accept; without the macro -> word read at 0x100.
